// File: rtl/i2c_req_arbiter_if.sv
// Requester and I2C-master command/status signals shared by the arbiter.
// slave = arbiter view, master = requester/master-model view.
interface i2c_req_arbiter_if #(
  parameter int N_REQ   = 4,
  parameter int ADDR_BW = 7,
  parameter int DATA_BW = 8
);
  logic [N_REQ-1:0]         i_req_valid;
  logic [N_REQ-1:0]         i_req_rw;
  logic [N_REQ*ADDR_BW-1:0] i_req_addr;
  logic [N_REQ*DATA_BW-1:0] i_req_data;
  logic [N_REQ-1:0]         o_req_ready;
  logic [N_REQ-1:0]         o_rsp_valid;
  logic [DATA_BW-1:0]       o_rsp_data;
  logic                     o_rsp_err;
  logic                     o_busy;
  logic                     o_ctl_enable;
  logic                     o_ctl_rw;
  logic [ADDR_BW-1:0]       o_ctl_addr;
  logic [DATA_BW-1:0]       o_ctl_data;
  logic                     i_ctl_tx_ready;
  logic [DATA_BW-1:0]       i_ctl_rx_data;

  modport slave (
    input  i_req_valid, i_req_rw, i_req_addr, i_req_data, i_ctl_tx_ready, i_ctl_rx_data,
    output o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_err, o_busy,
           o_ctl_enable, o_ctl_rw, o_ctl_addr, o_ctl_data
  );

  modport master (
    output i_req_valid, i_req_rw, i_req_addr, i_req_data, i_ctl_tx_ready, i_ctl_rx_data,
    input  o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_err, o_busy,
           o_ctl_enable, o_ctl_rw, o_ctl_addr, o_ctl_data
  );
endinterface

// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter sharing one I2C master between N_REQ requesters.
// Define I2C_ARB_TIMEOUT_EN to abort a command after TIMEOUT_CYC cycles with o_rsp_err.
module i2c_req_arbiter #(
  parameter int N_REQ       = 4,
  parameter int ADDR_BW     = 7,
  parameter int DATA_BW     = 8,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic             i_clk,
  input  logic             i_rst,
  i2c_req_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(N_REQ);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, RESP} state_t;

  state_t             state_reg;
  logic [PTR_W-1:0]   ptr_reg;
  logic [PTR_W-1:0]   grant_reg;
  logic               ctl_enable_reg;
  logic               ctl_rw_reg;
  logic [ADDR_BW-1:0] ctl_addr_reg;
  logic [DATA_BW-1:0] ctl_data_reg;
  logic [N_REQ-1:0]   rsp_valid_reg;
  logic [DATA_BW-1:0] rsp_data_reg;
  logic               rsp_err_reg;

  logic [ADDR_BW-1:0] req_addr [N_REQ];
  logic [DATA_BW-1:0] req_data [N_REQ];
  logic [PTR_W-1:0]   grant_idx;
  logic               grant_found;
  logic [N_REQ-1:0]   grant_onehot;
  logic               grant_go;
  logic               timeout_hit;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign req_addr[gi] = bus.i_req_addr[gi*ADDR_BW +: ADDR_BW];
      assign req_data[gi] = bus.i_req_data[gi*DATA_BW +: DATA_BW];
    end
  endgenerate

  // First pending requester strictly after the last grant, wrapping around.
  always_comb begin : rr_search
    int               cand;
    logic [PTR_W-1:0] cand_idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    cand_idx    = '0;
    for (int off = 1; off <= N_REQ; off++) begin
      cand = int'(ptr_reg) + off;
      if (cand >= N_REQ) cand = cand - N_REQ;
      cand_idx = PTR_W'(cand);
      if (!grant_found && bus.i_req_valid[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  assign grant_go     = (state_reg == IDLE) && grant_found && bus.i_ctl_tx_ready && !i_rst;
  assign grant_onehot = grant_go ? (N_REQ'(1) << grant_idx) : '0;

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  logic [CNT_W-1:0] to_cnt_reg;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      to_cnt_reg <= '0;
    else if (state_reg == IDLE)
      to_cnt_reg <= '0;
    else if (state_reg == ISSUE || state_reg == WAIT_DONE)
      to_cnt_reg <= to_cnt_reg + CNT_W'(1);
  end

  assign timeout_hit = (state_reg == ISSUE || state_reg == WAIT_DONE) &&
                       (to_cnt_reg == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg      <= IDLE;
      ptr_reg        <= PTR_W'(N_REQ - 1);
      grant_reg      <= '0;
      ctl_enable_reg <= 1'b0;
      ctl_rw_reg     <= 1'b0;
      ctl_addr_reg   <= '0;
      ctl_data_reg   <= '0;
      rsp_valid_reg  <= '0;
      rsp_data_reg   <= '0;
      rsp_err_reg    <= 1'b0;
    end else begin
      rsp_valid_reg <= '0;
      case (state_reg)
        IDLE: begin
          if (grant_go) begin
            grant_reg      <= grant_idx;
            ctl_rw_reg     <= bus.i_req_rw[grant_idx];
            ctl_addr_reg   <= req_addr[grant_idx];
            ctl_data_reg   <= req_data[grant_idx];
            ctl_enable_reg <= 1'b1;
            state_reg      <= ISSUE;
          end
        end
        ISSUE: begin
          if (timeout_hit) begin
            ctl_enable_reg <= 1'b0;
            rsp_valid_reg  <= N_REQ'(1) << grant_reg;
            rsp_data_reg   <= '0;
            rsp_err_reg    <= 1'b1;
            state_reg      <= RESP;
          end else if (!bus.i_ctl_tx_ready) begin
            // Dropping enable once the master starts makes it STOP rather than chain.
            ctl_enable_reg <= 1'b0;
            state_reg      <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          // A real completion wins over a simultaneous timeout.
          if (bus.i_ctl_tx_ready) begin
            rsp_valid_reg <= N_REQ'(1) << grant_reg;
            rsp_data_reg  <= bus.i_ctl_rx_data;
            rsp_err_reg   <= 1'b0;
            state_reg     <= RESP;
          end else if (timeout_hit) begin
            rsp_valid_reg <= N_REQ'(1) << grant_reg;
            rsp_data_reg  <= '0;
            rsp_err_reg   <= 1'b1;
            state_reg     <= RESP;
          end
        end
        RESP: begin
          ptr_reg   <= grant_reg;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.o_req_ready  = grant_onehot;
  assign bus.o_rsp_valid  = rsp_valid_reg;
  assign bus.o_rsp_data   = rsp_data_reg;
  assign bus.o_rsp_err    = rsp_err_reg;
  assign bus.o_busy       = (state_reg != IDLE);
  assign bus.o_ctl_enable = ctl_enable_reg;
  assign bus.o_ctl_rw     = ctl_rw_reg;
  assign bus.o_ctl_addr   = ctl_addr_reg;
  assign bus.o_ctl_data   = ctl_data_reg;
endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Scoreboard bench for i2c_req_arbiter: directed requester stimulus, a simple I2C
// master model, and a monitor that checks grants and responses against queued expectations.
module tb_i2c_req_arbiter;
  localparam int N  = 4;
  localparam int AW = 7;
  localparam int DW = 8;
  localparam int TC = 16;

  typedef struct packed {
    logic [N-1:0]  oh;
    logic          rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } grant_t;

  typedef struct packed {
    logic [N-1:0]  oh;
    logic [DW-1:0] data;
    logic          err;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  i2c_req_arbiter_if #(.N_REQ(N), .ADDR_BW(AW), .DATA_BW(DW)) bus ();

  i2c_req_arbiter #(.N_REQ(N), .ADDR_BW(AW), .DATA_BW(DW), .TIMEOUT_CYC(TC)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  grant_t        exp_grant [$];
  rsp_t          exp_rsp   [$];
  int            n_checks = 0;
  int            n_fail   = 0;
  logic [N-1:0]  hold_mask;
  int            m_drop, m_busy;
  logic [DW-1:0] m_rx;
  logic          m_hang;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic set_req(input int k, input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.i_req_rw[k]              = rw;
    bus.i_req_addr[k*AW +: AW]   = a;
    bus.i_req_data[k*DW +: DW]   = d;
  endtask

  task automatic push_grant(input int k, input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
    grant_t g;
    g.oh = N'(1) << k; g.rw = rw; g.addr = a; g.data = d;
    exp_grant.push_back(g);
    $display("push grant req%0d rw=%0b addr=0x%0h data=0x%0h", k, rw, a, d);
  endtask

  task automatic push_rsp(input int k, input logic [DW-1:0] d, input logic e);
    rsp_t r;
    r.oh = N'(1) << k; r.data = d; r.err = e;
    exp_rsp.push_back(r);
  endtask

  // One clock: sample at negedge, then auto-drop valid for accepted requesters.
  task automatic step(output logic [N-1:0] acc, output logic [N-1:0] rsp);
    @(negedge clk);
    acc = bus.o_req_ready;
    rsp = bus.o_rsp_valid;
    @(posedge clk); #1;
    bus.i_req_valid = bus.i_req_valid & ~(acc & ~hold_mask);
  endtask

  task automatic wait_idle(input int budget);
    logic [N-1:0] a, r;
    int i;
    for (i = 0; i < budget; i++) begin
      step(a, r);
      if (!bus.o_busy && bus.i_ctl_tx_ready && exp_grant.size() == 0 && exp_rsp.size() == 0) break;
    end
    chk("wait_idle_in_budget", 32'(i < budget), 32'd1);
  endtask

  task automatic check_zero(input string tag);
    $display("check outputs zero (%s)", tag);
    chk({tag, "_req_ready"},  32'(bus.o_req_ready),  32'd0);
    chk({tag, "_rsp_valid"},  32'(bus.o_rsp_valid),  32'd0);
    chk({tag, "_rsp_data"},   32'(bus.o_rsp_data),   32'd0);
    chk({tag, "_rsp_err"},    32'(bus.o_rsp_err),    32'd0);
    chk({tag, "_busy"},       32'(bus.o_busy),       32'd0);
    chk({tag, "_ctl_enable"}, 32'(bus.o_ctl_enable), 32'd0);
    chk({tag, "_ctl_rw"},     32'(bus.o_ctl_rw),     32'd0);
    chk({tag, "_ctl_addr"},   32'(bus.o_ctl_addr),   32'd0);
    chk({tag, "_ctl_data"},   32'(bus.o_ctl_data),   32'd0);
  endtask

  // I2C master model: sees enable, starts after m_drop cycles, finishes m_busy cycles later.
  initial begin : master_model
    bus.i_ctl_tx_ready = 1'b1;
    bus.i_ctl_rx_data  = '0;
    forever begin
      @(posedge clk); #1;
      if (bus.o_ctl_enable && bus.i_ctl_tx_ready && !m_hang) begin
        repeat (m_drop) @(posedge clk);
        #1 bus.i_ctl_tx_ready = 1'b0;
        repeat (m_busy) @(posedge clk);
        #1;
        bus.i_ctl_rx_data  = m_rx;
        bus.i_ctl_tx_ready = 1'b1;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a grant or response.
  int            mon_cyc = 0, mon_rise_cyc = -100, mon_grant_cyc = -100;
  logic          mon_prev_tx = 1'b1, mon_have_grant = 1'b0, mon_chk_en = 1'b0, mon_have_rsp = 1'b0;
  logic [DW-1:0] mon_held;
  grant_t        mon_cur;

  initial begin : monitor
    rsp_t r;
    forever begin
      @(negedge clk);
      mon_cyc++;
      if (rst) begin
        mon_have_grant = 1'b0;
        mon_have_rsp   = 1'b0;
        mon_chk_en     = 1'b0;
      end else begin
        if (mon_have_grant) begin
          chk("ctl_rw_stable",   32'(bus.o_ctl_rw),   32'(mon_cur.rw));
          chk("ctl_addr_stable", 32'(bus.o_ctl_addr), 32'(mon_cur.addr));
          chk("ctl_data_stable", 32'(bus.o_ctl_data), 32'(mon_cur.data));
        end
        if (mon_chk_en) chk("enable_after_accept", 32'(bus.o_ctl_enable), 32'd1);
        mon_chk_en = 1'b0;
        if (bus.o_busy && !mon_prev_tx) chk("enable_low_after_start", 32'(bus.o_ctl_enable), 32'd0);
        if (bus.i_ctl_tx_ready && !mon_prev_tx) mon_rise_cyc = mon_cyc;
        if (bus.o_req_ready != '0) begin
          chk("grant_needs_tx_ready", 32'(bus.i_ctl_tx_ready), 32'd1);
          if (exp_grant.size() == 0) begin
            chk("unexpected_grant", 32'(bus.o_req_ready), 32'd0);
          end else begin
            mon_cur = exp_grant.pop_front();
            $display("grant seen 0x%0h expected 0x%0h", bus.o_req_ready, mon_cur.oh);
            chk("grant_onehot", 32'(bus.o_req_ready), 32'(mon_cur.oh));
            mon_have_grant = 1'b1;
            mon_chk_en     = 1'b1;
            mon_grant_cyc  = mon_cyc;
          end
        end
        if (bus.o_rsp_valid != '0) begin
          if (exp_rsp.size() == 0) begin
            chk("unexpected_rsp", 32'(bus.o_rsp_valid), 32'd0);
          end else begin
            r = exp_rsp.pop_front();
            $display("rsp seen 0x%0h data=0x%0h err=%0b expected 0x%0h data=0x%0h err=%0b",
                     bus.o_rsp_valid, bus.o_rsp_data, bus.o_rsp_err, r.oh, r.data, r.err);
            chk("rsp_onehot", 32'(bus.o_rsp_valid), 32'(r.oh));
            chk("rsp_data",   32'(bus.o_rsp_data),  32'(r.data));
            chk("rsp_err",    32'(bus.o_rsp_err),   32'(r.err));
            chk("rsp_enable_low", 32'(bus.o_ctl_enable), 32'd0);
            if (r.err) chk("timeout_latency", 32'(mon_cyc - mon_grant_cyc), 32'(TC + 1));
            else       chk("rsp_latency",     32'(mon_cyc - mon_rise_cyc),  32'd1);
          end
          mon_held     = bus.o_rsp_data;
          mon_have_rsp = 1'b1;
        end else if (mon_have_rsp) begin
          chk("rsp_data_held", 32'(bus.o_rsp_data), 32'(mon_held));
        end
      end
      mon_prev_tx = bus.i_ctl_tx_ready;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [N-1:0] acc, rsp;
    int cnt;
    int order [5] = '{0, 1, 2, 3, 0};
    bus.i_req_valid = '0; bus.i_req_rw = '0; bus.i_req_addr = '0; bus.i_req_data = '0;
    hold_mask = '0; m_drop = 3; m_busy = 40; m_rx = '0; m_hang = 1'b0;
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_zero("reset");
    rst = 1'b0;

    // Fairness: all requesters held valid, expect 0,1,2,3,0.
    for (int k = 0; k < N; k++) set_req(k, 1'b0, AW'(8'h10 + k), DW'(8'hC0 + k));
    m_drop = 2; m_busy = 4; m_rx = 8'h22;
    foreach (order[i]) begin
      push_grant(order[i], 1'b0, AW'(8'h10 + order[i]), DW'(8'hC0 + order[i]));
      push_rsp(order[i], 8'h22, 1'b0);
    end
    hold_mask = '1; bus.i_req_valid = '1; cnt = 0;
    for (int i = 0; i < 400 && cnt < 5; i++) begin
      step(acc, rsp);
      if (acc != '0) cnt++;
    end
    chk("fair_grant_count", 32'(cnt), 32'd5);
    bus.i_req_valid = '0; hold_mask = '0;
    wait_idle(200);

    // Single write from req0.
    set_req(0, 1'b0, 7'h50, 8'hA5);
    m_drop = 3; m_busy = 40; m_rx = 8'h11;
    push_grant(0, 1'b0, 7'h50, 8'hA5); push_rsp(0, 8'h11, 1'b0);
    bus.i_req_valid = 4'b0001;
    wait_idle(300);

    // Read from req2.
    set_req(2, 1'b1, 7'h3C, 8'h00);
    m_drop = 2; m_busy = 10; m_rx = 8'h7E;
    push_grant(2, 1'b1, 7'h3C, 8'h00); push_rsp(2, 8'h7E, 1'b0);
    bus.i_req_valid = 4'b0100;
    wait_idle(200);

    // Reset during WAIT_DONE; pointer returns to N-1 so req0 beats req3.
    set_req(1, 1'b0, 7'h21, 8'hB1);
    m_drop = 2; m_busy = 30; m_rx = 8'h5A;
    push_grant(1, 1'b0, 7'h21, 8'hB1);
    bus.i_req_valid = 4'b0010;
    acc = '0;
    for (int i = 0; i < 50 && acc == '0; i++) step(acc, rsp);
    for (int i = 0; i < 50 && bus.i_ctl_tx_ready; i++) step(acc, rsp);
    chk("reset_test_started", 32'(bus.i_ctl_tx_ready), 32'd0);
    repeat (3) step(acc, rsp);
    rst = 1'b1;
    #1 check_zero("mid_reset");
    @(posedge clk); #1 rst = 1'b0;
    set_req(0, 1'b0, 7'h2A, 8'h90);
    set_req(3, 1'b1, 7'h68, 8'h00);
    push_grant(0, 1'b0, 7'h2A, 8'h90); push_rsp(0, 8'h5A, 1'b0);
    push_grant(3, 1'b1, 7'h68, 8'h00); push_rsp(3, 8'h5A, 1'b0);
    bus.i_req_valid = 4'b1001;
    wait_idle(400);

    // Withdrawn request: req1 drops during req0's RESP, so req3 is granted.
    set_req(0, 1'b0, 7'h11, 8'h01);
    set_req(1, 1'b0, 7'h12, 8'h02);
    set_req(3, 1'b0, 7'h13, 8'h03);
    m_drop = 2; m_busy = 6; m_rx = 8'h33;
    push_grant(0, 1'b0, 7'h11, 8'h01); push_rsp(0, 8'h33, 1'b0);
    push_grant(3, 1'b0, 7'h13, 8'h03); push_rsp(3, 8'h33, 1'b0);
    bus.i_req_valid = 4'b0001;
    acc = '0;
    for (int i = 0; i < 50 && acc == '0; i++) step(acc, rsp);
    bus.i_req_valid = bus.i_req_valid | 4'b1010;
    rsp = '0;
    for (int i = 0; i < 100 && rsp == '0; i++) step(acc, rsp);
    chk("withdraw_first_rsp", 32'(rsp), 32'd1);
    bus.i_req_valid[1] = 1'b0;
    wait_idle(200);

`ifdef I2C_ARB_TIMEOUT_EN
    // Timeout: master never starts.
    set_req(1, 1'b1, 7'h4B, 8'h00);
    m_hang = 1'b1;
    push_grant(1, 1'b1, 7'h4B, 8'h00); push_rsp(1, 8'h00, 1'b1);
    bus.i_req_valid = 4'b0010;
    wait_idle(200);
    m_hang = 1'b0;
`endif

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
